// File: rtl/phys_reg_file_mp.sv
// rtl/phys_reg_file_mp.sv - multi-port physical register file with ready bits and write-to-read bypass
// Tag 0 is hardwired zero; higher write ports win collisions; alloc beats writeback on ready.
module phys_reg_file_mp #(
  parameter int NUM_PREGS = 128,
  parameter int DATA_W    = 32,
  parameter int NUM_WR    = 3,
  parameter int NUM_RD    = 6,
  parameter int PTAG_W    = $clog2(NUM_PREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*PTAG_W-1:0]   wr_tag,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       alloc_en,
  input  logic [PTAG_W-1:0]          alloc_tag,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*PTAG_W-1:0]   rd_tag,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_ready,
  output logic                       wr_conflict
);

  logic [DATA_W-1:0]              r_mem [NUM_PREGS];
  logic [NUM_PREGS-1:0]           r_ready;
  logic [NUM_RD-1:0][DATA_W-1:0]  r_rd_data;
  logic [NUM_RD-1:0]              r_rd_ready;
  logic                           r_conflict;

  logic [NUM_WR-1:0]              w_wr_ok;
  logic                           w_alloc_ok;
  logic                           w_conflict;
  logic [NUM_RD-1:0][DATA_W-1:0]  w_rd_data;
  logic [NUM_RD-1:0]              w_rd_ready;

  function automatic logic tag_ok(input logic [PTAG_W-1:0] t);
    return (t != '0) && (32'(t) < NUM_PREGS);
  endfunction

  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < NUM_WR; p++)
      w_wr_ok[p] = wr_en[p] && tag_ok(wr_tag[p*PTAG_W +: PTAG_W]);
    w_alloc_ok = alloc_en && tag_ok(alloc_tag);
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (w_wr_ok[i] && w_wr_ok[j] &&
            wr_tag[i*PTAG_W +: PTAG_W] == wr_tag[j*PTAG_W +: PTAG_W])
          w_conflict = 1'b1;
  end

  // Post-edge view per read port: storage, then writes in ascending priority, then alloc.
  always_comb begin
    w_rd_data  = '0;
    w_rd_ready = '1;
    for (int r = 0; r < NUM_RD; r++) begin
      if (tag_ok(rd_tag[r*PTAG_W +: PTAG_W])) begin
        w_rd_data[r]  = r_mem[rd_tag[r*PTAG_W +: PTAG_W]];
        w_rd_ready[r] = r_ready[rd_tag[r*PTAG_W +: PTAG_W]];
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_wr_ok[p] && wr_tag[p*PTAG_W +: PTAG_W] == rd_tag[r*PTAG_W +: PTAG_W]) begin
            w_rd_data[r]  = wr_data[p*DATA_W +: DATA_W];
            w_rd_ready[r] = 1'b1;
          end
        end
        if (w_alloc_ok && alloc_tag == rd_tag[r*PTAG_W +: PTAG_W])
          w_rd_ready[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_PREGS; k++)
        r_mem[k] <= '0;
      r_ready <= '1;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_ok[p]) begin
          r_mem[wr_tag[p*PTAG_W +: PTAG_W]]   <= wr_data[p*DATA_W +: DATA_W];
          r_ready[wr_tag[p*PTAG_W +: PTAG_W]] <= 1'b1;
        end
      end
      if (w_alloc_ok)
        r_ready[alloc_tag] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_ready <= '1;
      r_conflict <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en[r]) begin
          r_rd_data[r]  <= w_rd_data[r];
          r_rd_ready[r] <= w_rd_ready[r];
        end
      end
      if (w_conflict)
        r_conflict <= 1'b1;
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_ready    = r_rd_ready;
  assign wr_conflict = r_conflict;

endmodule
